// File: rtl/and4_stim_chk_if.sv
// Bus between the AND4 stimulus/checker, its test controller and the cell under test.
// The master side drives run control and returns the cell output; the slave side is the checker.
interface and4_stim_chk_if #(
  parameter int PASS_W = 8,
  parameter int ERR_W  = 8
);
  logic              start;
  logic [PASS_W-1:0] passes;
  logic [3:0]        dut_in;
  logic              dut_q;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;
  logic              err_seen;
  logic [3:0]        first_err_vec;

  modport master (
    output start, passes, dut_q,
    input  dut_in, busy, done, err_cnt, err_seen, first_err_vec
  );

  modport slave (
    input  start, passes, dut_q,
    output dut_in, busy, done, err_cnt, err_seen, first_err_vec
  );
endinterface

// File: rtl/and4_stim_chk.sv
// Sweeps a 4-input AND cell through all 16 Gray-ordered vectors, waits SETTLE_CYC cycles,
// samples Q and counts mismatches. SETTLE_CYC+2 cycles per vector; START ignored while busy.
module and4_stim_chk #(
  parameter int SETTLE_CYC = 2,
  parameter int PASS_W     = 8,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  and4_stim_chk_if.slave   bus
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [PASS_W-1:0] pass, pass_nxt;
  logic [PASS_W-1:0] npass, npass_nxt;
  logic [SC_W-1:0]   scnt, scnt_nxt;
  logic [3:0]        dut_in, dut_in_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic [ERR_W-1:0]  err_cnt, err_cnt_nxt;
  logic              err_seen, err_seen_nxt;
  logic [3:0]        first_err_vec, first_err_vec_nxt;
  logic              mismatch;
  logic              last_vec;

  assign mismatch = bus.dut_q != (&dut_in);
  assign last_vec = (idx == 4'hF) && (pass == npass - PASS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    pass_nxt          = pass;
    npass_nxt         = npass;
    scnt_nxt          = scnt;
    dut_in_nxt        = dut_in;
    busy_nxt          = busy;
    done_nxt          = 1'b0;
    err_cnt_nxt       = err_cnt;
    err_seen_nxt      = err_seen;
    first_err_vec_nxt = first_err_vec;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt         = DRIVE;
          busy_nxt          = 1'b1;
          err_cnt_nxt       = '0;
          err_seen_nxt      = 1'b0;
          first_err_vec_nxt = '0;
          idx_nxt           = '0;
          pass_nxt          = '0;
          npass_nxt         = (bus.passes == '0) ? PASS_W'(1) : bus.passes;
        end
      end

      DRIVE: begin
        dut_in_nxt = idx ^ (idx >> 1);
        scnt_nxt   = '0;
        state_nxt  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
      end

      SETTLE: begin
        if (scnt == SC_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          scnt_nxt = scnt + SC_W'(1);
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          if (err_cnt != '1) begin
            err_cnt_nxt = err_cnt + ERR_W'(1);
          end
          if (!err_seen) begin
            err_seen_nxt      = 1'b1;
            first_err_vec_nxt = dut_in;
          end
        end
        // Error outputs are left holding so the controller can read them after DONE.
        if (last_vec) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          dut_in_nxt = '0;
        end else begin
          state_nxt = DRIVE;
          idx_nxt   = idx + 4'd1;
          if (idx == 4'hF) begin
            pass_nxt = pass + PASS_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      pass          <= '0;
      npass         <= '0;
      scnt          <= '0;
      dut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      err_seen      <= 1'b0;
      first_err_vec <= '0;
    end else begin
      idx           <= idx_nxt;
      pass          <= pass_nxt;
      npass         <= npass_nxt;
      scnt          <= scnt_nxt;
      dut_in        <= dut_in_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err_cnt       <= err_cnt_nxt;
      err_seen      <= err_seen_nxt;
      first_err_vec <= first_err_vec_nxt;
    end
  end

  assign bus.dut_in        = dut_in;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.err_cnt       = err_cnt;
  assign bus.err_seen      = err_seen;
  assign bus.first_err_vec = first_err_vec;

endmodule

// File: tb/tb_and4_stim_chk.sv
// Directed bench for and4_stim_chk: three instances (settle 2, 0, 1) driven from a scenario
// table, plus hand-written sequences for mid-run reset and ignored START pulses.
module tb_and4_stim_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] st = '0;
  logic [7:0] ps = 8'd1;
  int         qmode [3];
  logic [2:0] rq = '0;

  logic [3:0] din_a  [3];
  logic [7:0] ec_a   [3];
  logic [3:0] fev_a  [3];
  logic [2:0] busy_a, done_a, seen_a;

  and4_stim_chk_if #(.PASS_W(8), .ERR_W(8)) if0 ();
  and4_stim_chk_if #(.PASS_W(8), .ERR_W(8)) if1 ();
  and4_stim_chk_if #(.PASS_W(8), .ERR_W(8)) if2 ();

  and4_stim_chk #(.SETTLE_CYC(2), .PASS_W(8), .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  and4_stim_chk #(.SETTLE_CYC(0), .PASS_W(8), .ERR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  and4_stim_chk #(.SETTLE_CYC(1), .PASS_W(8), .ERR_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Cell models: 0 ideal AND, 1 stuck-0, 2 stuck-1, 3 AND with one register stage.
  function automatic logic qsel(input int m, input logic [3:0] d, input logic r);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return r;
      default: return &d;
    endcase
  endfunction

  always @(posedge clk) begin
    rq[0] <= &din_a[0];
    rq[1] <= &din_a[1];
    rq[2] <= &din_a[2];
  end

  assign if0.start = st[0]; assign if0.passes = ps; assign if0.dut_q = qsel(qmode[0], din_a[0], rq[0]);
  assign if1.start = st[1]; assign if1.passes = ps; assign if1.dut_q = qsel(qmode[1], din_a[1], rq[1]);
  assign if2.start = st[2]; assign if2.passes = ps; assign if2.dut_q = qsel(qmode[2], din_a[2], rq[2]);

  assign din_a[0] = if0.dut_in;  assign din_a[1] = if1.dut_in;  assign din_a[2] = if2.dut_in;
  assign ec_a[0]  = if0.err_cnt; assign ec_a[1]  = if1.err_cnt; assign ec_a[2]  = if2.err_cnt;
  assign fev_a[0] = if0.first_err_vec; assign fev_a[1] = if1.first_err_vec; assign fev_a[2] = if2.first_err_vec;
  assign busy_a = {if2.busy, if1.busy, if0.busy};
  assign done_a = {if2.done, if1.done, if0.done};
  assign seen_a = {if2.err_seen, if1.err_seen, if0.err_seen};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  typedef struct {
    int         sel;
    int         mode;
    int         np;
    int         cpv;
    int         lat;
    int         cnt;
    bit         seen;
    logic [3:0] first;
    bit         inj;
  } vec_t;

  vec_t tab [6];

  // One run: accept, Gray-order check on every drive edge of the first pass, DONE latency,
  // final error outputs, one-cycle DONE and no restart afterwards.
  task automatic run_check(input int s, input int mode, input int np, input int cpv,
                           input int exp_lat, input int exp_cnt, input bit exp_seen,
                           input logic [3:0] exp_first, input bit inj);
    int acc;
    int rel;
    int k;
    int lat;
    bit got;
    qmode[s] = mode;
    ps = 8'(np);
    @(negedge clk);
    st[s] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    st[s] = 1'b0;
    chk("busy_after_accept", 32'(busy_a[s]), 32'd1);
    got = 1'b0;
    k = 0;
    lat = 0;
    for (int n = 0; n < exp_lat + 20 && !got; n++) begin
      @(negedge clk);
      rel = cyc - acc;
      if (k < 16 && rel >= 1 && ((rel - 1) % cpv) == 0) begin
        chk($sformatf("gray_vec%0d_sel%0d", k, s), 32'(din_a[s]), 32'(gray_tab[k]));
        k++;
      end
      if (inj) st[s] = (rel == 10 || rel == exp_lat - 1);
      if (done_a[s]) begin
        got = 1'b1;
        lat = rel;
      end
    end
    st[s] = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout sel%0d: no DONE within %0d cycles", s, exp_lat + 20);
    end else begin
      chk("done_latency", 32'(lat), 32'(exp_lat));
    end
    chk("err_cnt", 32'(ec_a[s]), 32'(exp_cnt));
    chk("err_seen", 32'(seen_a[s]), 32'(exp_seen));
    chk("first_err_vec", 32'(fev_a[s]), 32'(exp_first));
    chk("busy_at_done", 32'(busy_a[s]), 32'd0);
    chk("dut_in_parked", 32'(din_a[s]), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_a[s]), 32'd0);
    repeat (2) @(negedge clk);
    chk("no_restart", 32'(busy_a[s]), 32'd0);
    chk("err_cnt_hold", 32'(ec_a[s]), 32'(exp_cnt));
  endtask

  initial begin
    int acc;
    qmode[0] = 0; qmode[1] = 0; qmode[2] = 0;

    tab[0] = '{0, 0, 1,  4, 64,   0,   1'b0, 4'h0, 1'b0};
    tab[1] = '{0, 1, 3,  4, 192,  3,   1'b1, 4'hF, 1'b0};
    tab[2] = '{0, 2, 20, 4, 1280, 255, 1'b1, 4'h0, 1'b0};
    tab[3] = '{1, 3, 1,  2, 32,   2,   1'b1, 4'hF, 1'b0};
    tab[4] = '{2, 3, 1,  3, 48,   0,   1'b0, 4'h0, 1'b0};
    tab[5] = '{0, 0, 0,  4, 64,   0,   1'b0, 4'h0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_dut_in", 32'(din_a[0]), 32'd0);
    chk("rst_err_cnt", 32'(ec_a[0]), 32'd0);
    chk("rst_err_seen", 32'(seen_a), 32'd0);
    chk("rst_first_err", 32'(fev_a[0]), 32'd0);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_check(tab[t].sel, tab[t].mode, tab[t].np, tab[t].cpv, tab[t].lat,
                tab[t].cnt, tab[t].seen, tab[t].first, tab[t].inj);
    end

    // Reset in the middle of a stuck-1 run, right after vector idx 7 is driven.
    qmode[0] = 2;
    ps = 8'd1;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    st[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrun_rel", 32'(cyc - acc), 32'd29);
    chk("midrun_dut_in", 32'(din_a[0]), 32'h4);
    chk("midrun_err_cnt", 32'(ec_a[0]), 32'd7);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a[0]), 32'd0);
    chk("arst_dut_in", 32'(din_a[0]), 32'd0);
    chk("arst_err_cnt", 32'(ec_a[0]), 32'd0);
    chk("arst_err_seen", 32'(seen_a[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(done_a[0]), 32'd0);
    chk("arst_idle", 32'(busy_a[0]), 32'd0);
    run_check(0, 0, 1, 4, 64, 0, 1'b0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
